// File: rtl/pong_pkg.sv
// Shared constants for the Pong video path: default widths, per-class colours
// and the compositing priority classes.
package pong_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int SIZE_W_DEF  = 8;
    localparam int COLOR_W_DEF = 3;

    localparam logic [COLOR_W_DEF-1:0] C_BG   = 3'd0;
    localparam logic [COLOR_W_DEF-1:0] C_WALL = 3'd1;
    localparam logic [COLOR_W_DEF-1:0] C_PAD0 = 3'd2;
    localparam logic [COLOR_W_DEF-1:0] C_PAD1 = 3'd3;
    localparam logic [COLOR_W_DEF-1:0] C_PADN = 3'd5;
    localparam logic [COLOR_W_DEF-1:0] C_BALL = 3'd7;

    // Ordered lowest to highest priority.
    typedef enum logic [1:0] {
        PRI_BG   = 2'd0,
        PRI_WALL = 2'd1,
        PRI_PAD  = 2'd2,
        PRI_BALL = 2'd3
    } pri_e;

    function automatic logic [COLOR_W_DEF-1:0] class_color(pri_e cls, int pad_idx);
        logic [COLOR_W_DEF-1:0] c;
        c = C_BG;
        case (cls)
            PRI_BALL: c = C_BALL;
            PRI_PAD:  c = (pad_idx == 0) ? C_PAD0 : (pad_idx == 1) ? C_PAD1 : C_PADN;
            PRI_WALL: c = C_WALL;
            default:  c = C_BG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pong_rect_hit.sv
// Combinational axis-aligned rectangle hit test; bounds are summed one bit
// wider than the coordinates so objects near the right/bottom edge never wrap.
module pong_rect_hit #(
    parameter int COORD_W = 10,
    parameter int SIZE_W  = 8
) (
    input  logic [COORD_W-1:0] xpix_i,
    input  logic [COORD_W-1:0] ypix_i,
    input  logic [COORD_W-1:0] x_obj_i,
    input  logic [COORD_W-1:0] y_obj_i,
    input  logic [SIZE_W-1:0]  w_i,
    input  logic [SIZE_W-1:0]  h_i,
    output logic               hit_o
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    assign x_end = {1'b0, x_obj_i} + {{(COORD_W+1-SIZE_W){1'b0}}, w_i};
    assign y_end = {1'b0, y_obj_i} + {{(COORD_W+1-SIZE_W){1'b0}}, h_i};

    assign in_x  = (xpix_i >= x_obj_i) && ({1'b0, xpix_i} < x_end);
    assign in_y  = (ypix_i >= y_obj_i) && ({1'b0, ypix_i} < y_end);
    assign hit_o = (w_i != '0) && (h_i != '0) && in_x && in_y;

endmodule

// File: rtl/pong_pixel_compositor.sv
// Two-stage pixel compositor: per-frame shadowed geometry, object hit tests,
// then fixed-priority colour selection (ball > paddles > wall > background).
module pong_pixel_compositor
    import pong_pkg::*;
#(
    parameter int N_PADDLES  = 2,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int SIZE_W     = SIZE_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int WALL_T     = 4,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic                           pix_valid_in,
    input  logic [COORD_W-1:0]             xpix,
    input  logic [COORD_W-1:0]             ypix,
    input  logic [COORD_W-1:0]             y_floor,
    input  logic [COORD_W-1:0]             y_ceil,
    input  logic [COORD_W-1:0]             x_lwall,
    input  logic [COORD_W-1:0]             x_rwall,
    input  logic [COORD_W-1:0]             x_ball,
    input  logic [COORD_W-1:0]             y_ball,
    input  logic [SIZE_W-1:0]              h_ball,
    input  logic [SIZE_W-1:0]              w_ball,
    input  logic [N_PADDLES*COORD_W-1:0]   x_pad,
    input  logic [N_PADDLES*COORD_W-1:0]   y_pad,
    input  logic [SIZE_W-1:0]              h_pad,
    input  logic [SIZE_W-1:0]              w_pad,
    input  logic                           blink_en,
    output logic                           pix_valid_out,
    output logic                           pix_on,
    output logic [COLOR_W-1:0]             pix_color,
    output logic [N_PADDLES+1:0]           hit_mask
);

    localparam int HW = N_PADDLES + 2;
    localparam logic [COORD_W:0] WALL_EXT = (COORD_W+1)'(WALL_T);

    logic [COORD_W-1:0]           y_floor_q, y_ceil_q, x_lwall_q, x_rwall_q;
    logic [COORD_W-1:0]           x_ball_q, y_ball_q;
    logic [SIZE_W-1:0]            h_ball_q, w_ball_q, h_pad_q, w_pad_q;
    logic [N_PADDLES*COORD_W-1:0] x_pad_q, y_pad_q;
    logic                         blink_q;
    logic [BLINK_LOG2-1:0]        frame_cnt_q;

    // Geometry only changes during vertical blank so a frame is drawn from one consistent snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_floor_q   <= '0;
            y_ceil_q    <= '0;
            x_lwall_q   <= '0;
            x_rwall_q   <= '0;
            x_ball_q    <= '0;
            y_ball_q    <= '0;
            h_ball_q    <= '0;
            w_ball_q    <= '0;
            x_pad_q     <= '0;
            y_pad_q     <= '0;
            h_pad_q     <= '0;
            w_pad_q     <= '0;
            blink_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            y_floor_q   <= y_floor;
            y_ceil_q    <= y_ceil;
            x_lwall_q   <= x_lwall;
            x_rwall_q   <= x_rwall;
            x_ball_q    <= x_ball;
            y_ball_q    <= y_ball;
            h_ball_q    <= h_ball;
            w_ball_q    <= w_ball;
            x_pad_q     <= x_pad;
            y_pad_q     <= y_pad;
            h_pad_q     <= h_pad;
            w_pad_q     <= w_pad;
            blink_q     <= blink_en;
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    logic [N_PADDLES:0] rect_hit;

    pong_rect_hit #(.COORD_W(COORD_W), .SIZE_W(SIZE_W)) u_ball_hit (
        .xpix_i (xpix),
        .ypix_i (ypix),
        .x_obj_i(x_ball_q),
        .y_obj_i(y_ball_q),
        .w_i    (w_ball_q),
        .h_i    (h_ball_q),
        .hit_o  (rect_hit[0])
    );

    for (genvar i = 0; i < N_PADDLES; i++) begin : g_pad
        pong_rect_hit #(.COORD_W(COORD_W), .SIZE_W(SIZE_W)) u_pad_hit (
            .xpix_i (xpix),
            .ypix_i (ypix),
            .x_obj_i(x_pad_q[i*COORD_W +: COORD_W]),
            .y_obj_i(y_pad_q[i*COORD_W +: COORD_W]),
            .w_i    (w_pad_q),
            .h_i    (h_pad_q),
            .hit_o  (rect_hit[i+1])
        );
    end

    logic [COORD_W:0] x_ext, y_ext;
    logic             in_box, in_band, wall_hit, ball_vis;

    assign x_ext  = {1'b0, xpix};
    assign y_ext  = {1'b0, ypix};
    assign in_box = (xpix >= x_lwall_q) && (xpix <= x_rwall_q) &&
                    (ypix >= y_ceil_q)  && (ypix <= y_floor_q);
    // Far-side bands are tested as pix+T > edge, which clamps at 0 without underflow.
    assign in_band = (y_ext < ({1'b0, y_ceil_q} + WALL_EXT))   ||
                     ((y_ext + WALL_EXT) > {1'b0, y_floor_q})  ||
                     (x_ext < ({1'b0, x_lwall_q} + WALL_EXT))  ||
                     ((x_ext + WALL_EXT) > {1'b0, x_rwall_q});
    assign wall_hit = in_box && in_band;
    // A hidden ball drops out of hit_mask as well, keeping pix_on == |hit_mask.
    assign ball_vis = !(blink_q && frame_cnt_q[BLINK_LOG2-1]);

    logic [HW-1:0] s1_hit_d, s1_hit_q;
    logic          s1_valid_q;

    assign s1_hit_d = pix_valid_in ? {wall_hit, rect_hit[N_PADDLES:1], rect_hit[0] & ball_vis}
                                   : '0;

    pri_e               cls;
    int                 pad_idx;
    logic [COLOR_W-1:0] color_d;

    always_comb begin
        cls     = PRI_BG;
        pad_idx = 0;
        if (s1_hit_q[HW-1]) cls = PRI_WALL;
        for (int i = N_PADDLES - 1; i >= 0; i--) begin
            if (s1_hit_q[i+1]) begin
                cls     = PRI_PAD;
                pad_idx = i;
            end
        end
        if (s1_hit_q[0]) cls = PRI_BALL;
        color_d = COLOR_W'(class_color(cls, pad_idx));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_q      <= '0;
            s1_valid_q    <= 1'b0;
            pix_valid_out <= 1'b0;
            pix_on        <= 1'b0;
            pix_color     <= '0;
            hit_mask      <= '0;
        end else begin
            s1_hit_q      <= s1_hit_d;
            s1_valid_q    <= pix_valid_in;
            pix_valid_out <= s1_valid_q;
            pix_on        <= |s1_hit_q;
            pix_color     <= color_d;
            hit_mask      <= s1_hit_q;
        end
    end

endmodule

// File: tb/tb_pong_pixel_compositor.sv
// Directed bench for pong_pixel_compositor with a rule-level reference model
// checked every cycle, plus literal spot checks on key pixels.
module tb_pong_pixel_compositor;

    localparam int NP = 2;
    localparam int CW = 10;
    localparam int SW = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_start = 1'b0;
    logic               pix_valid_in = 1'b0;
    logic [CW-1:0]      xpix = '0, ypix = '0;
    logic [CW-1:0]      y_floor = '0, y_ceil = '0, x_lwall = '0, x_rwall = '0;
    logic [CW-1:0]      x_ball = '0, y_ball = '0;
    logic [SW-1:0]      h_ball = '0, w_ball = '0;
    logic [NP*CW-1:0]   x_pad = '0, y_pad = '0;
    logic [SW-1:0]      h_pad = '0, w_pad = '0;
    logic               blink_en = 1'b0;
    logic               pix_valid_out, pix_on;
    logic [2:0]         pix_color;
    logic [NP+1:0]      hit_mask;

    pong_pixel_compositor #(.N_PADDLES(NP)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
        .xpix(xpix), .ypix(ypix), .y_floor(y_floor), .y_ceil(y_ceil),
        .x_lwall(x_lwall), .x_rwall(x_rwall), .x_ball(x_ball), .y_ball(y_ball),
        .h_ball(h_ball), .w_ball(w_ball), .x_pad(x_pad), .y_pad(y_pad),
        .h_pad(h_pad), .w_pad(w_pad), .blink_en(blink_en),
        .pix_valid_out(pix_valid_out), .pix_on(pix_on), .pix_color(pix_color),
        .hit_mask(hit_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int valid;
        int on;
        int color;
        int mask;
    } exp_t;

    // Model state: snapshot geometry as plain integers, frame count, pipeline slots.
    int sh_yf, sh_yc, sh_xl, sh_xr, sh_xb, sh_yb, sh_hb, sh_wb, sh_hp, sh_wp, sh_blink;
    int sh_xp[NP], sh_yp[NP];
    int frames;
    exp_t slot1, slot_out;

    function automatic bit in_rect(int x, int y, int xo, int yo, int w, int h);
        return (w > 0) && (h > 0) && (x >= xo) && (x < xo + w) && (y >= yo) && (y < yo + h);
    endfunction

    function automatic exp_t model(int x, int y, int v);
        exp_t e;
        bit ball, wall;
        bit pad[NP];
        e = '{valid: v, on: 0, color: 0, mask: 0};
        if (v == 0) return e;
        ball = in_rect(x, y, sh_xb, sh_yb, sh_wb, sh_hb) && !(sh_blink != 0 && frames >= 8);
        for (int i = 0; i < NP; i++) pad[i] = in_rect(x, y, sh_xp[i], sh_yp[i], sh_wp, sh_hp);
        wall = (x >= sh_xl) && (x <= sh_xr) && (y >= sh_yc) && (y <= sh_yf) &&
               ((y < sh_yc + 4) || (y > sh_yf - 4) || (x < sh_xl + 4) || (x > sh_xr - 4));
        e.mask = int'(ball) + 2 * int'(pad[0]) + 4 * int'(pad[1]) + 8 * int'(wall);
        e.on   = (e.mask != 0) ? 1 : 0;
        if (ball)        e.color = 7;
        else if (pad[0]) e.color = 2;
        else if (pad[1]) e.color = 3;
        else if (wall)   e.color = 1;
        else             e.color = 0;
        return e;
    endfunction

    task automatic chk(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        sh_yf = 0; sh_yc = 0; sh_xl = 0; sh_xr = 0; sh_xb = 0; sh_yb = 0;
        sh_hb = 0; sh_wb = 0; sh_hp = 0; sh_wp = 0; sh_blink = 0; frames = 0;
        for (int i = 0; i < NP; i++) begin sh_xp[i] = 0; sh_yp[i] = 0; end
        slot1    = '{valid: 0, on: 0, color: 0, mask: 0};
        slot_out = '{valid: 0, on: 0, color: 0, mask: 0};
    endtask

    // One clock: advance the model alongside the DUT, then compare all outputs.
    task automatic step();
        exp_t e;
        e = model(int'(xpix), int'(ypix), int'(pix_valid_in));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            slot_out = slot1;
            slot1    = e;
            if (frame_start) begin
                sh_yf = int'(y_floor); sh_yc = int'(y_ceil);
                sh_xl = int'(x_lwall); sh_xr = int'(x_rwall);
                sh_xb = int'(x_ball);  sh_yb = int'(y_ball);
                sh_hb = int'(h_ball);  sh_wb = int'(w_ball);
                sh_hp = int'(h_pad);   sh_wp = int'(w_pad);
                sh_blink = int'(blink_en);
                for (int i = 0; i < NP; i++) begin
                    sh_xp[i] = int'(x_pad[i*CW +: CW]);
                    sh_yp[i] = int'(y_pad[i*CW +: CW]);
                end
                frames = (frames + 1) % 16;
            end
        end
        #1;
        chk("valid_out", int'(pix_valid_out), slot_out.valid);
        chk("pix_on",    int'(pix_on),        slot_out.on);
        chk("pix_color", int'(pix_color),     slot_out.color);
        chk("hit_mask",  int'(hit_mask),      slot_out.mask);
    endtask

    // Present one pixel, then an idle slot, so the pixel is at the outputs on return.
    task automatic pix(input logic [CW-1:0] x, input logic [CW-1:0] y);
        xpix = x; ypix = y; pix_valid_in = 1'b1;
        step();
        pix_valid_in = 1'b0;
        step();
    endtask

    task automatic fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; pix_valid_in = 1'b1; xpix = 10'd50; ypix = 10'd50;
        repeat (3) step();
        chk("rst_valid", int'(pix_valid_out), 0);
        chk("rst_color", int'(pix_color), 0);
        chk("rst_mask",  int'(hit_mask), 0);
        rst = 1'b0;
        step();
        chk("rel1_valid", int'(pix_valid_out), 0);
        step();
        chk("rel2_valid", int'(pix_valid_out), 1);
        pix_valid_in = 1'b0;
        step();

        x_lwall = 10'd10; x_rwall = 10'd600; y_ceil = 10'd20; y_floor = 10'd460;
        x_ball = 10'd100; y_ball = 10'd100; w_ball = 8'd8; h_ball = 8'd8;
        x_pad = {10'd500, 10'd96}; y_pad = {10'd200, 10'd96};
        w_pad = 8'd8; h_pad = 8'd32;
        fs();

        pix(10'd107, 10'd107); chk("ball_corner", int'(pix_color), 7);
        pix(10'd108, 10'd107); chk("ball_past",   int'(pix_color), 0);
        pix(10'd100, 10'd100); chk("overlap_col", int'(pix_color), 7);
        chk("overlap_mask", int'(hit_mask), 4'b0011);
        pix(10'd97, 10'd120);  chk("pad0_only",   int'(pix_color), 2);
        pix(10'd503, 10'd210); chk("pad1_only",   int'(pix_color), 3);
        pix(10'd300, 10'd23);  chk("ceil_band",   int'(pix_color), 1);
        pix(10'd300, 10'd24);  chk("ceil_past",   int'(pix_color), 0);
        pix(10'd12, 10'd200);  chk("lwall_band",  int'(pix_color), 1);
        pix(10'd300, 10'd458); chk("floor_band",  int'(pix_color), 1);

        x_ball = 10'd200;
        pix(10'd104, 10'd104); chk("old_pos",     int'(pix_color), 7);
        pix(10'd204, 10'd104); chk("new_pre_fs",  int'(pix_color), 0);
        fs();
        pix(10'd204, 10'd104); chk("new_post_fs", int'(pix_color), 7);
        pix(10'd104, 10'd104); chk("old_post_fs", int'(pix_color), 0);

        // Back-to-back pixels plus an invalid slot in between.
        xpix = 10'd205; ypix = 10'd105; pix_valid_in = 1'b1; step();
        xpix = 10'd300; ypix = 10'd22;  step();
        pix_valid_in = 1'b0; xpix = 10'd205; step();
        pix_valid_in = 1'b1; xpix = 10'd98; ypix = 10'd110; step();
        pix_valid_in = 1'b0; step(); step();

        x_ball = 10'd1020; y_ball = 10'd300;
        fs();
        pix(10'd3, 10'd300);    chk("nowrap_mask",  int'(hit_mask), 0);
        chk("nowrap_color", int'(pix_color), 0);
        pix(10'd1023, 10'd300); chk("edge_ball",    int'(pix_color), 7);

        // Mid-frame reset with valid pixels streaming.
        pix_valid_in = 1'b1; xpix = 10'd300; ypix = 10'd22;
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk("flush_valid1", int'(pix_valid_out), 0);
        step();
        chk("flush_valid2", int'(pix_valid_out), 1);
        chk("flush_geom0",  int'(pix_color), 0);
        pix_valid_in = 1'b0; step();

        x_ball = 10'd200; y_ball = 10'd100; blink_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            fs();
            pix(10'd204, 10'd104);
            case (k)
                7:  chk("blink_f7",  int'(pix_on), 1);
                8:  chk("blink_f8",  int'(pix_on), 0);
                15: chk("blink_f15", int'(pix_on), 0);
                16: chk("blink_f16", int'(pix_on), 1);
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
